// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, load/store func3 codes, the memory FSM states,
// the WB-bound register bundle and the misaligned/illegal memory-op check.
package rv32_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} state_e;

    typedef struct packed {
        logic              valid;
        logic [4:0]        rd;
        logic [2:0]        func3;
        logic [6:0]        opcode;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] pc;
        logic              lt;
        logic              ltu;
        logic              exc;
    } wb_t;

    // True when a load/store must not reach the bus: unknown width or unaligned address.
    function automatic logic mem_op_bad(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (is_load) begin
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end else begin
            illegal = (f3 >= 3'b011);
        end
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte/half from the bus word and
// sign- or zero-extends it according to the load func3.
module load_align
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_i,
    input  logic [2:0]      func3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'b00:   byte_sel = rdata_i[7:0];
            2'b01:   byte_sel = rdata_i[15:8];
            2'b10:   byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (func3_i)
            F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores over a req/ack bus, stalls the pipe while
// waiting, aligns load data and registers everything WB consumes.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [4:0]        rd,
    input  logic [2:0]        func3,
    input  logic [6:0]        opcode,
    input  logic [XLEN-1:0]   result,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              lt,
    input  logic              ltu,
    input  logic [XLEN-1:0]   PC,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              valid_WB,
    output logic [4:0]        rd_WBin,
    output logic [2:0]        func3_WB,
    output logic [6:0]        opcode_WB,
    output logic [XLEN-1:0]   read_data,
    output logic [XLEN-1:0]   result_WB,
    output logic [XLEN-1:0]   PC_WB,
    output logic              lt_WB,
    output logic              ltu_WB,
    output logic              mem_exc
);

    state_e            state_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [XLEN-1:0]   req_wdata_q;
    logic [3:0]        req_be_q;
    logic              req_we_q;
    logic              flush_q;
    logic [4:0]        h_rd_q;
    logic [2:0]        h_func3_q;
    logic [6:0]        h_opcode_q;
    logic [XLEN-1:0]   h_result_q;
    logic [XLEN-1:0]   h_pc_q;
    logic              h_lt_q;
    logic              h_ltu_q;
    wb_t               wb_d;
    wb_t               wb_q;

    logic            is_load;
    logic            is_store;
    logic            is_mem;
    logic            bad;
    logic            drop;
    logic            take;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_data;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load || is_store;
    assign bad      = is_mem && mem_op_bad(is_load, func3, result[1:0]);
    assign drop     = flush || !valid_in;
    assign take     = (state_q == IDLE) && !drop && is_mem && !bad;

    assign stall    = (state_q == IDLE) ? take : !dmem_ack;
    assign dmem_req = (state_q == WAIT);
    assign dmem_we    = req_we_q;
    assign dmem_addr  = req_addr_q;
    assign dmem_wdata = req_wdata_q;
    assign dmem_be    = req_be_q;

    always_comb begin
        case (func3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << result[1:0];
                st_wdata = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                st_be    = result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = rs2_data;
            end
        endcase
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata_i(dmem_rdata),
        .addr_i (h_result_q[1:0]),
        .func3_i(h_func3_q),
        .data_o (ld_data)
    );

    // Request and instruction fields are captured at issue so they stay stable through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            req_we_q    <= 1'b0;
            flush_q     <= 1'b0;
            h_rd_q      <= '0;
            h_func3_q   <= '0;
            h_opcode_q  <= '0;
            h_result_q  <= '0;
            h_pc_q      <= '0;
            h_lt_q      <= 1'b0;
            h_ltu_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q     <= WAIT;
                        req_addr_q  <= {result[ADDR_W-1:2], 2'b00};
                        req_wdata_q <= st_wdata;
                        req_be_q    <= st_be;
                        req_we_q    <= is_store;
                        flush_q     <= 1'b0;
                        h_rd_q      <= rd;
                        h_func3_q   <= func3;
                        h_opcode_q  <= opcode;
                        h_result_q  <= result;
                        h_pc_q      <= PC;
                        h_lt_q      <= lt;
                        h_ltu_q     <= ltu;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        flush_q <= flush_q || flush;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        wb_d = '0;
        if (state_q == IDLE) begin
            if (!drop && !take) begin
                wb_d.valid  = 1'b1;
                wb_d.func3  = func3;
                wb_d.opcode = opcode;
                wb_d.result = result;
                wb_d.pc     = PC;
                wb_d.lt     = lt;
                wb_d.ltu    = ltu;
                // A faulting op retires with rd=0 so WB writes nothing.
                if (bad) begin
                    wb_d.exc = 1'b1;
                end else begin
                    wb_d.rd = rd;
                end
            end
        end else if (dmem_ack && !flush_q && !flush) begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = h_rd_q;
            wb_d.func3     = h_func3_q;
            wb_d.opcode    = h_opcode_q;
            wb_d.result    = h_result_q;
            wb_d.pc        = h_pc_q;
            wb_d.lt        = h_lt_q;
            wb_d.ltu       = h_ltu_q;
            wb_d.read_data = req_we_q ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign valid_WB  = wb_q.valid;
    assign rd_WBin   = wb_q.rd;
    assign func3_WB  = wb_q.func3;
    assign opcode_WB = wb_q.opcode;
    assign read_data = wb_q.read_data;
    assign result_WB = wb_q.result;
    assign PC_WB     = wb_q.pc;
    assign lt_WB     = wb_q.lt;
    assign ltu_WB    = wb_q.ltu;
    assign mem_exc   = wb_q.exc;

endmodule
